// File: rtl/sk_keymem_loader.sv
// Secret-key loader: streams 32-bit sk words from the register API into
// consecutive key-memory addresses. Optional checksum: ABR_SK_LOADER_CHECKSUM_EN.

package sk_keymem_pkg;
  localparam int ABR_MEM_ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10
  } mem_rw_mode_e;

  typedef struct packed {
    mem_rw_mode_e                  rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;
endpackage

module sk_keymem_loader
  import sk_keymem_pkg::*;
#(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int CNT_W          = 11
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          zeroize,
  input  logic                          load_start,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_W-1:0]              num_words,
  input  logic                          sk_wr_valid,
  output logic                          sk_wr_ready,
  input  logic [AHB_DATA_WIDTH-1:0]     sk_wr_data,
  input  logic                          sk_wr_last,
  input  logic                          keymem_wr_stall,
  output mem_if_t                       keymem_wr_req,
  output logic [AHB_DATA_WIDTH-1:0]     keymem_wr_data,
  output logic                          sk_load_busy,
  output logic                          sk_load_done,
  output logic                          sk_load_error,
`ifdef ABR_SK_LOADER_CHECKSUM_EN
  output logic [AHB_DATA_WIDTH-1:0]     sk_checksum,
`endif
  output logic [CNT_W-1:0]              word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    DONE  = 2'b10,
    ERROR = 2'b11
  } state_e;

  state_e                          state, next_state;
  logic                            clear;
  logic                            start_ok;
  logic                            accept;
  logic                            is_final;
  logic                            last_err;
  logic                            commit;
  logic [ABR_MEM_ADDR_WIDTH-1:0]   base_q;
  logic [CNT_W-1:0]                num_q;
  logic                            error_q;

  assign clear    = reset | zeroize;
  assign start_ok = load_start & ((state == IDLE) | (state == ERROR));
  assign accept   = (state == LOAD) & sk_wr_valid & ~keymem_wr_stall;
  assign is_final = (word_cnt == (num_q - CNT_W'(1)));
  // A last flag that disagrees with the programmed length drops the word.
  assign last_err = is_final ^ sk_wr_last;
  assign commit   = accept & ~last_err;

  assign sk_load_error = error_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    sk_wr_ready  = 1'b0;
    sk_load_busy = 1'b0;
    sk_load_done = 1'b0;
    unique case (state)
      IDLE, ERROR: begin
        if (load_start) next_state = (num_words == '0) ? DONE : LOAD;
      end
      LOAD: begin
        sk_wr_ready  = ~keymem_wr_stall;
        sk_load_busy = 1'b1;
        if (accept) begin
          if (last_err)      next_state = ERROR;
          else if (is_final) next_state = DONE;
        end
      end
      DONE: begin
        sk_load_done = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      keymem_wr_req  <= '{rd_wr_en: RW_IDLE, addr: '0};
      keymem_wr_data <= '0;
      word_cnt       <= '0;
      base_q         <= '0;
      num_q          <= '0;
      error_q        <= 1'b0;
    end else begin
      keymem_wr_req.rd_wr_en <= RW_IDLE;
      if (start_ok) begin
        base_q   <= base_addr;
        num_q    <= num_words;
        word_cnt <= '0;
        error_q  <= 1'b0;
      end
      if (accept) word_cnt <= word_cnt + CNT_W'(1);
      if (commit) begin
        // Address wraps silently modulo the key-memory size.
        keymem_wr_req  <= '{rd_wr_en: RW_WRITE,
                            addr: base_q + ABR_MEM_ADDR_WIDTH'(word_cnt)};
        keymem_wr_data <= sk_wr_data;
      end
      if (accept & last_err) error_q <= 1'b1;
    end
  end

`ifdef ABR_SK_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (clear || start_ok) begin
      sk_checksum <= '0;
    end else if (commit) begin
      sk_checksum <= {sk_checksum[AHB_DATA_WIDTH-2:0], sk_checksum[AHB_DATA_WIDTH-1]}
                     ^ sk_wr_data;
    end
  end
`endif

endmodule

// File: doc/sk_keymem_loader.md
Name: sk_keymem_loader

Overview:
Upstream feeder for the secret-key decode stage. Accepts the ML-DSA secret key as a stream of 32-bit words from the register/AHB API. Writes each word to consecutive key-memory addresses starting at a programmed base. Pulses a done strobe when the last word is committed, so the high-level controller can then launch sk decoding.

Parameters:
AHB_DATA_WIDTH, 32, width of one sk word and of the key-memory write data
CNT_W, 11, width of the word counter (max load 2047 words; ML-DSA-87 sk = 1224 words)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
zeroize  input  1  synchronous clear, same effect as reset
load_start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE or ERROR
base_addr  input  ABR_MEM_ADDR_WIDTH  first key-memory address; latched on load_start
num_words  input  CNT_W  word count; latched on load_start
sk_wr_valid  input  1  input word valid
sk_wr_ready  output  1  word accepted when valid & ready
sk_wr_data  input  AHB_DATA_WIDTH  sk word
sk_wr_last  input  1  marks the final word of the key
keymem_wr_stall  input  1  key-memory port busy (decoder reading); blocks acceptance
keymem_wr_req  output  mem_if_t  key-memory write request: rd_wr_en and addr
keymem_wr_data  output  AHB_DATA_WIDTH  key-memory write data
sk_load_busy  output  1  high in LOAD
sk_load_done  output  1  one-cycle pulse
sk_load_error  output  1  sticky error flag
word_cnt  output  CNT_W  words accepted in the current load

Behaviour:
- Clocking and reset: one clock domain (clk). reset is synchronous and active-high. zeroize is also synchronous and has identical effect.
- Reset/zeroize values: state IDLE; keymem_wr_req.rd_wr_en = RW_IDLE; addr, data and word_cnt = 0; sk_wr_ready, sk_load_busy, sk_load_done, sk_load_error = 0.
- Reset/zeroize mid-LOAD: the load is aborted with no further writes and no done pulse.
- FSM states: IDLE, LOAD, DONE, ERROR.
- IDLE/ERROR + load_start:
  - latch base_addr and num_words; clear word_cnt and error.
  - if num_words==0, go to DONE; otherwise go to LOAD.
- LOAD:
  - sk_wr_ready = ~keymem_wr_stall (combinational).
  - Each accepted word is registered. In the next cycle the block drives keymem_wr_req = {RW_WRITE, base+word_cnt_old} with keymem_wr_data = the word. Latency is 1 cycle.
  - word_cnt increments on every accept.
  - Address arithmetic is modulo 2^ABR_MEM_ADDR_WIDTH; wrap-around is silent.
- Last-word check:
  - Accepting word index num_words-1 with sk_wr_last=1: write it, then go to DONE.
  - Index num_words-1 with sk_wr_last=0, or sk_wr_last=1 at an earlier index: the word is dropped (no write), sk_load_error=1, go to ERROR.
- Stall and valid: if keymem_wr_stall and sk_wr_valid are both high, no accept occurs and the word is held by the source. While valid is low, rd_wr_en=RW_IDLE.
- DONE: sk_load_done=1 for exactly one cycle. This is the same cycle the final write appears on keymem_wr_req (or the cycle after load_start when num_words=0). Next state is IDLE.
- ERROR: sticky until load_start, reset or zeroize. sk_wr_ready=0.
- Ignored pulses: load_start in LOAD or DONE is ignored.
- Idle handshake: sk_wr_valid in IDLE is not accepted (ready=0).

Optional Feature:
- Macro: ABR_SK_LOADER_CHECKSUM_EN.
- Compiled in:
  - Adds output sk_checksum [AHB_DATA_WIDTH-1:0].
  - Cleared on load_start, reset and zeroize.
  - On each committed write it updates as checksum = {checksum[30:0],checksum[31]} ^ word.
  - Valid and stable from the sk_load_done cycle until the next load_start.
  - Dropped (error) words are not folded in.
- Compiled out: the port and its logic are absent. All other behaviour is unchanged.

Test Plan:
- Basic load: base=0x100, num_words=4, words 0xA0..0xA3 back-to-back, last on the 4th -> writes to 0x100..0x103 at accept+1 cycle; done pulses with the 0x103 write; word_cnt=4; error=0.
- Stall: keymem_wr_stall high for 3 cycles mid-load with valid high -> ready low for those 3 cycles, no writes, no lost or duplicated words; addresses stay contiguous.
- Last-word mismatch:
  - Early last: sk_wr_last on word index 1 of 4 -> no write for that word; error=1; ERROR state; ready=0; a new load_start clears error.
  - Missing last: last absent on word index 3 of 4 -> same response.
- Zero length and wrap:
  - num_words=0 -> done pulses the cycle after load_start with no writes.
  - base=max address, num_words=2 -> second write goes to address 0.
- Abort/zeroize: zeroize asserted after 2 of 8 words -> next cycle all outputs are at reset values; no done pulse; a subsequent load succeeds.
- Checksum (macro on): words 0x1, 0x2 -> sk_checksum=0x00000000 after the 2nd word (rotl(0x1)^0x2=0x0); words 0x1, 0x3 -> 0x00000001.
